// File: rtl/mul_error_monitor_pkg.sv
// Shared types and sizing for the approximate-multiplier error monitor.
package mul_error_monitor_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 17;

    // Wide enough for (2^(2*width)-1) * (2^cnt_w-1), so the sum never wraps.
    function automatic int acc_w(input int width, input int cnt_w);
        return 2 * width + cnt_w;
    endfunction

endpackage

// File: rtl/mul_abs_err.sv
// Exact unsigned product and its absolute distance from an approximate product.
module mul_abs_err
    import mul_error_monitor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] r_approx,
    output logic [2*WIDTH-1:0] exact,
    output logic [2*WIDTH-1:0] abs_err
);

    assign exact   = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    assign abs_err = (exact >= r_approx) ? (exact - r_approx) : (r_approx - exact);

endmodule

// File: rtl/mul_error_monitor.sv
// Collects error count, summed and maximum absolute error of an approximate
// multiplier over a programmed number of samples.
module mul_error_monitor
    import mul_error_monitor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = acc_w(WIDTH, CNT_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] r_approx,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [ACC_W-1:0]   sum_abs_err,
    output logic [2*WIDTH-1:0] max_abs_err,
    output logic [WIDTH-1:0]   max_a,
    output logic [WIDTH-1:0]   max_b
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] num_lat;
    logic             drain_cnt;
    logic             accept;
    logic             start_ok;

    assign in_ready = (state == RUN);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (num_samples != '0) ? RUN : DONE;
            RUN:        if (accept && (sample_count + CNT_W'(1) == num_lat)) state_nxt = DRAIN;
            DRAIN:      if (drain_cnt) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Two DRAIN cycles let the last sample clear stages 2 and 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            drain_cnt    <= 1'b0;
            num_lat      <= '0;
            sample_count <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (start_ok) begin
                num_lat      <= num_samples;
                sample_count <= '0;
            end else if (accept) begin
                sample_count <= sample_count + CNT_W'(1);
            end
        end
    end

    // Stage 1: capture the accepted sample.
    logic [WIDTH-1:0]   a_p0, b_p0;
    logic [2*WIDTH-1:0] r_p0;
    logic               vld_p0;

    always_ff @(posedge clk) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= a;
            b_p0 <= b;
            r_p0 <= r_approx;
        end
    end

    logic [2*WIDTH-1:0] exact_c, abs_err_c;

    mul_abs_err #(.WIDTH(WIDTH)) u_abs_err (
        .a        (a_p0),
        .b        (b_p0),
        .r_approx (r_p0),
        .exact    (exact_c),
        .abs_err  (abs_err_c)
    );

    // Stage 2: register the error magnitude alongside its operands.
    logic [WIDTH-1:0]   a_p1, b_p1;
    logic [2*WIDTH-1:0] abs_err_p1;
    logic               err_p1;
    logic               vld_p1;

    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            a_p1       <= a_p0;
            b_p1       <= b_p0;
            abs_err_p1 <= abs_err_c;
            err_p1     <= (exact_c != r_p0);
        end
    end

    // Stage 3: fold into the statistics; strict compare keeps the earliest maximum.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            max_a       <= '0;
            max_b       <= '0;
        end else if (vld_p1) begin
            err_count   <= err_count + CNT_W'(err_p1);
            sum_abs_err <= sum_abs_err + ACC_W'(abs_err_p1);
            if (abs_err_p1 > max_abs_err) begin
                max_abs_err <= abs_err_p1;
                max_a       <= a_p1;
                max_b       <= b_p1;
            end
        end
    end

endmodule

// File: tb/tb_mul_error_monitor.sv
// Bench for mul_error_monitor: table-driven runs with a per-run scoreboard plus
// hand-written abort, start-ignore and random-traffic sequences.
module tb_mul_error_monitor;

    localparam int W  = 8;
    localparam int CW = 17;
    localparam int AW = 2 * W + CW;

    logic          clk, rst, start, in_valid, in_ready, busy, done;
    logic [CW-1:0] num_samples, sample_count, err_count;
    logic [W-1:0]  a, b, max_a, max_b;
    logic [2*W-1:0] r_approx, max_abs_err;
    logic [AW-1:0] sum_abs_err;

    mul_error_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .r_approx(r_approx),
        .busy(busy), .done(done), .sample_count(sample_count), .err_count(err_count),
        .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err), .max_a(max_a), .max_b(max_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [7:0] a; logic [7:0] b; logic [15:0] r; } smp_t;
    typedef struct { int n; int mode; longint err; longint sum; longint mx; longint ma; longint mb; } run_t;
    typedef struct { int n; longint err; longint sum; longint mx; longint ma; longint mb; } exp_t;

    smp_t stim[$];
    smp_t tbl_smp[$];
    exp_t sb[$];
    run_t runs[4];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sample_count"}, sample_count, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_sum_abs_err"}, sum_abs_err, 0);
        chk({tag, "_max_abs_err"}, max_abs_err, 0);
        chk({tag, "_max_a"}, max_a, 0);
        chk({tag, "_max_b"}, max_b, 0);
    endtask

    // Reference statistics computed straight from the stimulus.
    task automatic model_push(input int n);
        exp_t e;
        longint ex, ae;
        e = '{n, 0, 0, 0, 0, 0};
        for (int i = 0; i < n; i++) begin
            ex = longint'(stim[i].a) * longint'(stim[i].b);
            ae = (ex > longint'(stim[i].r)) ? ex - longint'(stim[i].r) : longint'(stim[i].r) - ex;
            if (ae != 0) e.err++;
            e.sum += ae;
            if (ae > e.mx) begin
                e.mx = ae;
                e.ma = longint'(stim[i].a);
                e.mb = longint'(stim[i].b);
            end
        end
        sb.push_back(e);
    endtask

    // mode 0: valid every cycle, 1: pattern 1,0,1,1,0,1 then high, 2: random valid.
    task automatic do_run(input int n, input int mode);
        exp_t e;
        int   hs, s, k;
        bit   v;
        bit   pat [6];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        start = 1'b1; num_samples = CW'(n); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            chk("zero_done_next_cycle", done, 1);
            chk("zero_in_ready", in_ready, 0);
        end else begin
            chk("run_in_ready", in_ready, 1);
            hs = 0; s = 0;
            while (hs < n && s < 500) begin
                if (mode == 1)      v = (s < 6) ? pat[s] : 1'b1;
                else if (mode == 2) v = 1'($urandom_range(0, 1));
                else                v = 1'b1;
                in_valid = v;
                if (v) begin
                    a = stim[hs].a; b = stim[hs].b; r_approx = stim[hs].r;
                end else begin
                    {a, b, r_approx} = $urandom;
                end
                if (v && in_ready) hs++;
                if (hs < n) begin
                    @(negedge clk);
                    s++;
                end
            end
            chk("handshakes", hs, n);
            @(negedge clk);
            k = 1;
            chk("in_ready_after_last", in_ready, 0);
            while (!done && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("done_latency", k, 3);
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        chk("sample_count", sample_count, e.n);
        chk("err_count", err_count, e.err);
        chk("sum_abs_err", sum_abs_err, e.sum);
        chk("max_abs_err", max_abs_err, e.mx);
        chk("max_a", max_a, e.ma);
        chk("max_b", max_b, e.mb);
        @(negedge clk);
        chk("done_held", done, 1);
        chk("sum_held", sum_abs_err, e.sum);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p;
        int ex;
        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        a = '0; b = '0; r_approx = '0;

        runs[0] = '{1, 0, 0, 0, 0, 0, 0};
        runs[1] = '{3, 0, 2, 8, 4, 10, 10};
        runs[2] = '{4, 1, 3, 11, 6, 4, 4};
        runs[3] = '{0, 0, 0, 0, 0, 0, 0};
        tbl_smp.push_back('{8'd3,   8'd5,   16'd15});
        tbl_smp.push_back('{8'd10,  8'd10,  16'd96});
        tbl_smp.push_back('{8'd255, 8'd255, 16'd65025});
        tbl_smp.push_back('{8'd7,   8'd8,   16'd60});
        tbl_smp.push_back('{8'd1,   8'd1,   16'd1});
        tbl_smp.push_back('{8'd2,   8'd3,   16'd7});
        tbl_smp.push_back('{8'd4,   8'd4,   16'd10});
        tbl_smp.push_back('{8'd9,   8'd9,   16'd85});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        // Start during RUN is ignored; reset after two samples discards them.
        stim.delete();
        stim.push_back('{8'd10, 8'd10, 16'd96});
        stim.push_back('{8'd7,  8'd8,  16'd60});
        @(negedge clk);
        start = 1'b1; num_samples = CW'(5);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; a = stim[0].a; b = stim[0].b; r_approx = stim[0].r;
        @(negedge clk);
        chk("abort_count1", sample_count, 1);
        a = stim[1].a; b = stim[1].b; r_approx = stim[1].r;
        start = 1'b1; num_samples = CW'(1);
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_count", sample_count, 2);
        chk("start_ignored_ready", in_ready, 1);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("abort");
        repeat (3) @(negedge clk);
        chk("abort_flush_sum", sum_abs_err, 0);
        chk("abort_flush_err", err_count, 0);

        p = 0;
        for (int i = 0; i < 4; i++) begin
            stim.delete();
            for (int j = 0; j < runs[i].n; j++) begin
                stim.push_back(tbl_smp[p]);
                p++;
            end
            sb.push_back('{runs[i].n, runs[i].err, runs[i].sum, runs[i].mx, runs[i].ma, runs[i].mb});
            do_run(runs[i].n, runs[i].mode);
        end

        // Random traffic with a duplicated sample to exercise tie handling.
        stim.delete();
        for (int i = 0; i < 24; i++) begin
            smp_t sm;
            sm.a = 8'($urandom); sm.b = 8'($urandom);
            ex = int'(sm.a) * int'(sm.b);
            case ($urandom_range(0, 3))
                0: sm.r = 16'(ex);
                1: sm.r = 16'((ex + int'($urandom_range(1, 300)) > 65535) ? 65535 : ex + int'($urandom_range(1, 300)));
                2: sm.r = 16'((ex < 300) ? 0 : ex - int'($urandom_range(1, 300)));
                default: sm.r = 16'($urandom);
            endcase
            stim.push_back(sm);
        end
        stim[17] = stim[5];
        model_push(24);
        do_run(24, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
